// File: rtl/aes_round_ctrl.sv
`timescale 1ns/1ps
// AES-128 round sequencer: 10 rounds of DP_LAT+1 cycles each, ciphertext valid 10*(DP_LAT+1) edges after accept.
// Accepts a job only when idle; holds the ciphertext in DONE until out_ready; abort cancels a running job.
module aes_round_ctrl #(
  parameter int unsigned DP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  input  logic         abort,
  output logic         busy,
  output logic [3:0]   rc,
  output logic [127:0] sub_key,
  output logic [127:0] state_arr,
  output logic         final_round,
  input  logic [127:0] keyout,
  input  logic [127:0] roundout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [2:0] LAT        = 3'(DP_LAT);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [2:0]   cnt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic         capture;
  logic [3:0]   round_nxt;

  assign capture   = (cnt == LAT);
  assign round_nxt = round + 4'd1;

  assign ciphertext = state_reg;
  assign state_arr  = state_reg;
  assign sub_key    = key_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      round       <= 4'd0;
      cnt         <= 3'd0;
      state_reg   <= '0;
      key_reg     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      rc          <= 4'd0;
      final_round <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_reg   <= plaintext ^ key;
            key_reg     <= key;
            round       <= 4'd1;
            cnt         <= 3'd0;
            fsm         <= RUN;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            rc          <= 4'd1;
            final_round <= 1'b0;
          end
        end
        RUN: begin
          // abort takes priority over a round capture in the same cycle
          if (abort) begin
            fsm         <= IDLE;
            cnt         <= 3'd0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            rc          <= 4'd0;
            final_round <= 1'b0;
          end else if (capture) begin
            state_reg <= roundout;
            key_reg   <= keyout;
            cnt       <= 3'd0;
            if (round == LAST_ROUND) begin
              fsm         <= DONE;
              out_valid   <= 1'b1;
              busy        <= 1'b0;
              rc          <= 4'd0;
              final_round <= 1'b0;
            end else begin
              round       <= round_nxt;
              rc          <= round_nxt;
              final_round <= (round_nxt == LAST_ROUND);
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter DP_LAT, default 1, meaning: clock cycles from round-datapath input change to valid roundout/keyout; legal range 0..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  block accepts new job.
REQ-006 plaintext  input  128  block to encrypt.
REQ-007 key  input  128  AES-128 cipher key.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ciphertext  output  128  encrypted block.
REQ-011 abort  input  1  cancel job in progress.
REQ-012 busy  output  1  job in RUN state.
REQ-013 rc  output  4  round number 1..10 to round datapath.
REQ-014 sub_key  output  128  previous round key to datapath key expansion.
REQ-015 state_arr  output  128  current state to datapath.
REQ-016 final_round  output  1  high when rc==10; datapath bypasses mixcolumn.
REQ-017 keyout  input  128  next round key from datapath.
REQ-018 roundout  input  128  next state from datapath.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE only; encoding free.
REQ-020 IDLE: in_ready=1; on in_valid, state_reg<=plaintext^key, key_reg<=key, round<=1, cnt<=0, go RUN.
REQ-021 in_ready SHALL be 1 only in IDLE; in_valid in RUN/DONE ignored, no input captured.
REQ-022 RUN: busy=1; rc=round, sub_key=key_reg, state_arr=state_reg, final_round=(round==10), all driven from registers.
REQ-023 RUN: cnt increments each cycle; when cnt==DP_LAT, state_reg<=roundout, key_reg<=keyout, cnt<=0.
REQ-024 At capture with round<10: round<=round+1, stay RUN; with round==10: go DONE, round unchanged.
REQ-025 Each round SHALL take exactly DP_LAT+1 cycles; out_valid rises 10*(DP_LAT+1) edges after the accepting edge.
REQ-026 DONE: out_valid=1, ciphertext=state_reg held stable until handshake; on out_ready go IDLE.
REQ-027 out_valid and in_ready SHALL never be high together; next job accepted no earlier than cycle after out handshake.
REQ-028 abort in RUN: go IDLE next edge, no capture that cycle, out_valid never asserted for the job; abort in IDLE/DONE ignored.
REQ-029 abort and capture in same cycle: abort wins.
REQ-030 Outside RUN: rc=0, final_round=0; sub_key and state_arr hold last register values.
REQ-031 round counter SHALL never exceed 10 nor be 0 while in RUN.

Reset
REQ-032 rst high at any edge, incl. mid-RUN or DONE: state IDLE, in_ready=1, out_valid=0, busy=0, rc=0, final_round=0, cnt=0, round=0, state_reg=0, key_reg=0, ciphertext=0.
REQ-033 rst SHALL override in_valid, abort and out_ready in the same cycle; no job accepted while rst high.

Verification
REQ-034 DP_LAT=1, real round datapath: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 20 edges after accept.
REQ-035 DP_LAT=0: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32 after 10 edges; final_round high only while rc==10.
REQ-036 out_ready held 0 for 5 cycles in DONE -> ciphertext stable, in_ready=0, second in_valid ignored; job accepted cycle after out_ready=1.
REQ-037 abort asserted in round 4 -> IDLE next edge, no out_valid; new job afterwards yields correct ciphertext.
REQ-038 rst asserted in round 7 -> all outputs at REQ-032 values next cycle; in_valid with rst high not accepted.
REQ-039 Back-to-back jobs with out_ready tied 1 and in_valid tied 1 -> one accept per 10*(DP_LAT+1)+2 cycles, each ciphertext correct.
